// File: rtl/casez_match_engine_if.sv
// Subject/result bus of the casez match engine: subject + mode/default in, result out.
// No storage of its own; valid/ready on both sides.
// The master drives subjects and out_ready; the slave (engine) drives in_ready and results.
interface casez_match_engine_if #(
    parameter int WIDTH = 4,
    parameter int RES_W = 8,
    parameter int IDX_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] in_zmask;
    logic             mode;
    logic [RES_W-1:0] default_res;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_res;
    logic             out_hit;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, in_val, in_zmask, mode, default_res, out_ready,
        input  in_ready, out_valid, out_res, out_hit, out_idx
    );

    modport slave (
        input  in_valid, in_val, in_zmask, mode, default_res, out_ready,
        output in_ready, out_valid, out_res, out_hit, out_idx
    );
endinterface

// File: rtl/casez_match_engine.sv
// Programmable priority pattern classifier with case / casez bit semantics.
// Latency 2 cycles from accept to out_valid, 1 result per cycle.
// out_valid & ~out_ready freezes both stages and drops in_ready; cfg writes never stall.
module casez_match_engine #(
    parameter int WIDTH   = 4,
    parameter int ENTRIES = 4,
    parameter int RES_W   = 8,
    parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    casez_match_engine_if.slave  bus,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [WIDTH-1:0]     cfg_val,
    input  logic [WIDTH-1:0]     cfg_zmask,
    input  logic [RES_W-1:0]     cfg_res,
    input  logic                 cfg_en,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    typedef struct packed {
        logic             en;
        logic [WIDTH-1:0] val;
        logic [WIDTH-1:0] zm;
        logic [RES_W-1:0] res;
    } entry_t;

    entry_t tbl_q [ENTRIES];
    entry_t tbl_d [ENTRIES];

    logic                            s1_vld_q, s1_vld_d;
    logic [ENTRIES-1:0]              s1_hit_q, s1_hit_d;
    logic [ENTRIES-1:0][RES_W-1:0]   s1_res_q, s1_res_d;
    logic [RES_W-1:0]                s1_def_q, s1_def_d;

    logic                            out_valid_q, out_valid_d;
    logic [RES_W-1:0]                out_res_q, out_res_d;
    logic                            out_hit_q, out_hit_d;
    logic [IDX_W-1:0]                out_idx_q, out_idx_d;
    logic [CNT_W-1:0]                hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                miss_cnt_q, miss_cnt_d;

    logic                            stall;
    logic                            accept;
    logic [WIDTH-1:0]                bit_ok;
    logic [ENTRIES-1:0]              hit_now;
    logic                            win_hit;
    logic [IDX_W-1:0]                win_idx;
    logic [RES_W-1:0]                win_res;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res  = out_res_q;
    assign bus.out_hit  = out_hit_q;
    assign bus.out_idx  = out_idx_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

    // Table write and match both look at tbl_q, so a same-cycle subject sees the old table.
    always_comb begin
        tbl_d   = tbl_q;
        bit_ok  = '0;
        hit_now = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (cfg_we && cfg_idx == IDX_W'(e)) begin
                tbl_d[e] = '{en: cfg_en, val: cfg_val, zm: cfg_zmask, res: cfg_res};
            end
            if (bus.mode) begin
                bit_ok = tbl_q[e].zm | bus.in_zmask | ~(tbl_q[e].val ^ bus.in_val);
            end else begin
                bit_ok = ~(tbl_q[e].val ^ bus.in_val) & ~(tbl_q[e].zm ^ bus.in_zmask);
            end
            hit_now[e] = tbl_q[e].en & (&bit_ok);
        end
    end

    // Stage 1 snapshots the entry results too, so later table writes cannot leak in.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_hit_d = s1_hit_q;
        s1_res_d = s1_res_q;
        s1_def_d = s1_def_q;
        if (!stall) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_hit_d = hit_now;
                s1_def_d = bus.default_res;
                for (int e = 0; e < ENTRIES; e++) begin
                    s1_res_d[e] = tbl_q[e].res;
                end
            end
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        win_res = s1_def_q;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (s1_hit_q[e]) begin
                win_hit = 1'b1;
                win_idx = IDX_W'(e);
                win_res = s1_res_q[e];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (!stall) begin
            out_valid_d = s1_vld_q;
            if (s1_vld_q) begin
                out_res_d = win_res;
                out_hit_d = win_hit;
                out_idx_d = win_idx;
            end
        end
        if (out_valid_q && bus.out_ready) begin
            if (out_hit_q) begin
                if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ENTRIES; e++) begin
                tbl_q[e] <= '0;
            end
            s1_vld_q    <= 1'b0;
            s1_hit_q    <= '0;
            s1_res_q    <= '0;
            s1_def_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            tbl_q       <= tbl_d;
            s1_vld_q    <= s1_vld_d;
            s1_hit_q    <= s1_hit_d;
            s1_res_q    <= s1_res_d;
            s1_def_q    <= s1_def_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_casez_match_engine.sv
// Scoreboard bench for casez_match_engine: driver predicts from a symbolic table model,
// a monitor checks each delivered result, counters, stall stability and reset state.
module tb_casez_match_engine;
    localparam int WIDTH   = 4;
    localparam int ENTRIES = 4;
    localparam int RES_W   = 8;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [RES_W-1:0] res;
        bit               hit;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    casez_match_engine_if #(.WIDTH(WIDTH), .RES_W(RES_W), .IDX_W(IDX_W)) bus ();

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [WIDTH-1:0] cfg_val;
    logic [WIDTH-1:0] cfg_zmask;
    logic [RES_W-1:0] cfg_res;
    logic             cfg_en;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    casez_match_engine #(
        .WIDTH(WIDTH), .ENTRIES(ENTRIES), .RES_W(RES_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_val(cfg_val), .cfg_zmask(cfg_zmask),
        .cfg_res(cfg_res), .cfg_en(cfg_en), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Reference table: each bit is a symbol 0, 1, z0 (2) or z1 (3).
    bit               m_en  [ENTRIES];
    logic [WIDTH-1:0] m_val [ENTRIES];
    logic [WIDTH-1:0] m_zm  [ENTRIES];
    logic [RES_W-1:0] m_res [ENTRIES];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_hit  = 0;
    int   n_miss = 0;

    bit               pw_we = 0;
    logic [IDX_W-1:0] pw_idx;
    logic [WIDTH-1:0] pw_val, pw_zm;
    logic [RES_W-1:0] pw_res;
    bit               pw_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sym(bit v, bit z);
        return z ? 2 + int'(v) : int'(v);
    endfunction

    function automatic exp_t predict(logic [WIDTH-1:0] sv, logic [WIDTH-1:0] sz,
                                     bit md, logic [RES_W-1:0] dr);
        exp_t r;
        r.res = dr;
        r.hit = 0;
        r.idx = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            bit ok;
            ok = m_en[e];
            for (int b = 0; b < WIDTH; b++) begin
                int p;
                int s;
                p = sym(m_val[e][b], m_zm[e][b]);
                s = sym(sv[b], sz[b]);
                if (md) begin
                    if (!(p >= 2 || s >= 2 || p == s)) ok = 0;
                end else begin
                    if (p != s) ok = 0;
                end
            end
            if (ok) begin
                r.res = m_res[e];
                r.hit = 1;
                r.idx = IDX_W'(e);
                return r;
            end
        end
        return r;
    endfunction

    task automatic queue_write(input int idx, input logic [WIDTH-1:0] v,
                               input logic [WIDTH-1:0] z, input logic [RES_W-1:0] r,
                               input bit en);
        pw_we  = 1;
        pw_idx = IDX_W'(idx);
        pw_val = v;
        pw_zm  = z;
        pw_res = r;
        pw_en  = en;
    endtask

    task automatic step(input bit v, input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] sz,
                        input bit md, input logic [RES_W-1:0] dr, input bit ordy,
                        output bit acc);
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_val      = sv;
        bus.in_zmask    = sz;
        bus.mode        = md;
        bus.default_res = dr;
        bus.out_ready   = ordy;
        cfg_we    = pw_we;
        cfg_idx   = pw_idx;
        cfg_val   = pw_val;
        cfg_zmask = pw_zm;
        cfg_res   = pw_res;
        cfg_en    = pw_en;
        pw_we     = 0;
        #1;
        acc = v && bus.in_ready;
        if (acc) sb.push_back(predict(sv, sz, md, dr));
        if (cfg_we) begin
            m_en[cfg_idx]  = cfg_en;
            m_val[cfg_idx] = cfg_val;
            m_zm[cfg_idx]  = cfg_zmask;
            m_res[cfg_idx] = cfg_res;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] sz,
                        input bit md, input logic [RES_W-1:0] dr);
        bit acc;
        int tries;
        tries = 0;
        acc = 0;
        while (!acc && tries < 20) begin
            step(1'b1, sv, sz, md, dr, 1'b1, acc);
            tries++;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        repeat (n) step(1'b0, '0, '0, 1'b0, '0, ordy, acc);
    endtask

    task automatic clear_model();
        for (int e = 0; e < ENTRIES; e++) begin
            m_en[e]  = 0;
            m_val[e] = '0;
            m_zm[e]  = '0;
            m_res[e] = '0;
        end
    endtask

    // Monitor: samples 2 time units after the falling edge.
    initial begin
        bit               prev_stall;
        logic [RES_W-1:0] p_res;
        logic             p_hit;
        logic [IDX_W-1:0] p_idx;
        exp_t             e;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_out_res", 32'(bus.out_res), 32'd0);
                chk("rst_out_hit", 32'(bus.out_hit), 32'd0);
                chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
                chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
                chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
                prev_stall = 0;
            end else begin
                chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
                chk("hit_cnt", 32'(hit_cnt), 32'(n_hit));
                chk("miss_cnt", 32'(miss_cnt), 32'(n_miss));
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_res", 32'(bus.out_res), 32'(p_res));
                    chk("stall_hit", 32'(bus.out_hit), 32'(p_hit));
                    chk("stall_idx", 32'(bus.out_idx), 32'(p_idx));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_res", 32'(bus.out_res), 32'(e.res));
                        chk("out_hit", 32'(bus.out_hit), 32'(e.hit));
                        chk("out_idx", 32'(bus.out_idx), 32'(e.idx));
                        if (e.hit) n_hit++;
                        else n_miss++;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                p_res = bus.out_res;
                p_hit = bus.out_hit;
                p_idx = bus.out_idx;
            end
        end
    end

    initial begin
        bit acc;
        bus.in_valid = 0; bus.in_val = '0; bus.in_zmask = '0; bus.mode = 0;
        bus.default_res = '0; bus.out_ready = 0;
        cfg_we = 0; cfg_idx = '0; cfg_val = '0; cfg_zmask = '0; cfg_res = '0; cfg_en = 0;
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Table: e0 = 11??, e1 = 10zz, e2 = 0100, e3 disabled.
        queue_write(0, 4'b1100, 4'b0011, 8'd1, 1); idle(1, 1);
        queue_write(1, 4'b1000, 4'b0011, 8'd2, 1); idle(1, 1);
        queue_write(2, 4'b0100, 4'b0000, 8'd3, 1); idle(1, 1);

        send(4'b1100, 4'b0000, 1, 8'd0);
        send(4'b1011, 4'b0000, 1, 8'd0);
        send(4'b0100, 4'b0000, 1, 8'd0);
        send(4'b0000, 4'b0000, 1, 8'd0);
        idle(4, 1);

        // Exact mode
        send(4'b1100, 4'b0000, 0, 8'd0);
        send(4'b1100, 4'b0011, 0, 8'd0);
        send(4'b0100, 4'b0000, 0, 8'd0);
        idle(4, 1);

        // Fully-z subject in casez mode, then with e0 disabled
        send(4'b0000, 4'b1111, 1, 8'd0);
        queue_write(0, 4'b1100, 4'b0011, 8'd1, 0); idle(1, 1);
        send(4'b0000, 4'b1111, 1, 8'd0);
        queue_write(0, 4'b1100, 4'b0011, 8'd1, 1); idle(1, 1);

        // Backpressure burst
        send(4'b1100, 4'b0000, 1, 8'd7);
        send(4'b1011, 4'b0000, 1, 8'd7);
        send(4'b0100, 4'b0000, 1, 8'd7);
        send(4'b0001, 4'b0000, 1, 8'd7);
        idle(3, 0);
        idle(6, 1);

        // Same-cycle rewrite of e0 sees the old table
        queue_write(0, 4'b1100, 4'b0011, 8'd9, 1);
        send(4'b1100, 4'b0000, 1, 8'd0);
        send(4'b1100, 4'b0000, 1, 8'd0);
        idle(4, 1);

        // Random traffic with random config writes and backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                queue_write(int'($urandom_range(0, ENTRIES - 1)), WIDTH'($urandom),
                            WIDTH'($urandom) & WIDTH'($urandom), RES_W'($urandom),
                            $urandom_range(0, 4) != 0);
            end
            step($urandom_range(0, 3) != 0, WIDTH'($urandom),
                 WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom),
                 1'($urandom), RES_W'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        idle(6, 1);

        // Reset with two items in flight, first one parked at the output
        send(4'b1100, 4'b0000, 1, 8'd0);
        send(4'b1011, 4'b0000, 1, 8'd0);
        idle(1, 0);
        @(negedge clk);
        rst_n = 0;
        bus.in_valid = 0;
        sb.delete();
        n_hit = 0;
        n_miss = 0;
        pw_we = 0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1;
        send(4'b1100, 4'b0000, 1, 8'h55);
        idle(6, 1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
